// File: rtl/nco_sweep_if.sv
// Host-side register/control port and sweep outputs of the NCO frequency-sweep generator.
// The host (master) drives writes and sweep control; the sweep engine (slave) returns the increment word.
interface nco_sweep_if #(
    parameter int W = 32
);
    logic         ce;
    logic         wr;
    logic [1:0]   addr;
    logic [W-1:0] din;
    logic         go;
    logic         mode;
    logic         abort;
    logic [W-1:0] freq;
    logic         active;
    logic         done;

    modport master (
        output ce, wr, addr, din, go, mode, abort,
        input  freq, active, done
    );

    modport slave (
        input  ce, wr, addr, din, go, mode, abort,
        output freq, active, done
    );
endinterface

// File: rtl/nco_sweep.sv
// Linear frequency-sweep generator feeding the phase-increment (B) input of the NCO accumulator.
// Shadow registers are copied to working registers at every load, so host writes never disturb a running sweep.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no sweep; FREQ holds last value, waits for GO
//   ST_RUN  | stepping FREQ towards STOP_F once per DWELL+1 CE pulses
//   ST_END  | one cycle at STOP_F with DONE high; reload (repeat) or return to idle
module nco_sweep #(
    parameter int W  = 32,
    parameter int DW = 16
) (
    input  logic       clk,
    input  logic       sclr,
    nco_sweep_if.slave sw
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_t;

    localparam logic [1:0] A_START = 2'd0;
    localparam logic [1:0] A_STOP  = 2'd1;
    localparam logic [1:0] A_STEP  = 2'd2;
    localparam logic [1:0] A_DWELL = 2'd3;

    state_t        state_q, state_d;

    logic [W-1:0]  start_f_q, start_f_d;
    logic [W-1:0]  stop_f_q,  stop_f_d;
    logic [W-1:0]  step_q,    step_d;
    logic [DW-1:0] dwell_q,   dwell_d;

    logic [W-1:0]  w_stop_q,  w_stop_d;
    logic [W-1:0]  w_step_q,  w_step_d;
    logic [DW-1:0] w_dwell_q, w_dwell_d;
    logic [DW-1:0] cnt_q,     cnt_d;
    logic          dir_up_q,  dir_up_d;

    logic [W-1:0]  freq_q,    freq_d;
    logic          active_q,  active_d;
    logic          done_q,    done_d;

    logic [W:0]    sum_w;
    logic [W:0]    diff_w;
    logic          do_load;

    // One extra bit catches carry/borrow so the sweep clamps instead of wrapping.
    assign sum_w  = {1'b0, freq_q} + {1'b0, w_step_q};
    assign diff_w = {1'b0, freq_q} - {1'b0, w_step_q};

    always_comb begin
        state_d   = state_q;
        start_f_d = start_f_q;
        stop_f_d  = stop_f_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        w_stop_d  = w_stop_q;
        w_step_d  = w_step_q;
        w_dwell_d = w_dwell_q;
        cnt_d     = cnt_q;
        dir_up_d  = dir_up_q;
        freq_d    = freq_q;
        active_d  = active_q;
        done_d    = 1'b0;
        do_load   = 1'b0;

        if (sw.wr) begin
            case (sw.addr)
                A_START: start_f_d = sw.din;
                A_STOP:  stop_f_d  = sw.din;
                A_STEP:  step_d    = sw.din;
                A_DWELL: dwell_d   = sw.din[DW-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                active_d = 1'b0;
                if (sw.go && !sw.abort) begin
                    do_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (sw.abort) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end else if (sw.ce) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = w_dwell_q;
                        if (dir_up_q) begin
                            if (sum_w[W] || (sum_w[W-1:0] >= w_stop_q)) begin
                                freq_d  = w_stop_q;
                                state_d = ST_END;
                                done_d  = 1'b1;
                            end else begin
                                freq_d = sum_w[W-1:0];
                            end
                        end else begin
                            if (diff_w[W] || (diff_w[W-1:0] <= w_stop_q)) begin
                                freq_d  = w_stop_q;
                                state_d = ST_END;
                                done_d  = 1'b1;
                            end else begin
                                freq_d = diff_w[W-1:0];
                            end
                        end
                    end
                end
            end
            ST_END: begin
                if (sw.abort || !sw.mode) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end else begin
                    do_load = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
            end
        endcase

        // Load always uses the registered shadow values, not a write landing this cycle.
        if (do_load) begin
            freq_d    = start_f_q;
            cnt_d     = dwell_q;
            w_stop_d  = stop_f_q;
            w_step_d  = step_q;
            w_dwell_d = dwell_q;
            dir_up_d  = (stop_f_q >= start_f_q);
            active_d  = 1'b1;
            if (start_f_q == stop_f_q) begin
                state_d = ST_END;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q   <= ST_IDLE;
            start_f_q <= '0;
            stop_f_q  <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            w_stop_q  <= '0;
            w_step_q  <= '0;
            w_dwell_q <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b0;
            freq_q    <= '0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_f_q <= start_f_d;
            stop_f_q  <= stop_f_d;
            step_q    <= step_d;
            dwell_q   <= dwell_d;
            w_stop_q  <= w_stop_d;
            w_step_q  <= w_step_d;
            w_dwell_q <= w_dwell_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            freq_q    <= freq_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign sw.freq   = freq_q;
    assign sw.active = active_q;
    assign sw.done   = done_q;
endmodule

// File: tb/tb_nco_sweep.sv
// Cycle-level bench for nco_sweep: every driven cycle queues the expected FREQ/ACTIVE/DONE,
// which are popped and compared one cycle later.
module tb_nco_sweep;
    logic clk = 1'b0;
    logic sclr;

    nco_sweep_if #(.W(32)) bus ();

    nco_sweep #(.W(32), .DW(16)) dut (
        .clk  (clk),
        .sclr (sclr),
        .sw   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] freq_q[$];
    logic        act_q[$];
    logic        done_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input bit ce_i, input bit go_i, input bit abort_i,
                       input logic [31:0] ef, input bit ea, input bit ed, input string tag);
        string       t;
        logic [31:0] f;
        logic        a;
        logic        d;
        bus.ce    = ce_i;
        bus.go    = go_i;
        bus.abort = abort_i;
        tag_q.push_back(tag);
        freq_q.push_back(ef);
        act_q.push_back(ea);
        done_q.push_back(ed);
        @(posedge clk);
        #1;
        bus.wr    = 1'b0;
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        t = tag_q.pop_front();
        f = freq_q.pop_front();
        a = act_q.pop_front();
        d = done_q.pop_front();
        check_val({t, ".freq"},   bus.freq,          f);
        check_val({t, ".active"}, {31'd0, bus.active}, {31'd0, a});
        check_val({t, ".done"},   {31'd0, bus.done},   {31'd0, d});
    endtask

    task automatic set_wr(input logic [1:0] a, input logic [31:0] v);
        bus.wr   = 1'b1;
        bus.addr = a;
        bus.din  = v;
    endtask

    task automatic wr_all(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                          input logic [31:0] dw, input logic [31:0] hold_f);
        set_wr(2'd0, st);  cyc(0, 0, 0, hold_f, 0, 0, "wr_start");
        set_wr(2'd1, sp);  cyc(0, 0, 0, hold_f, 0, 0, "wr_stop");
        set_wr(2'd2, stp); cyc(0, 0, 0, hold_f, 0, 0, "wr_step");
        set_wr(2'd3, dw);  cyc(0, 0, 0, hold_f, 0, 0, "wr_dwell");
    endtask

    initial begin
        logic [31:0] ef;
        sclr      = 1'b1;
        bus.ce    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 2'd0;
        bus.din   = '0;
        bus.go    = 1'b0;
        bus.mode  = 1'b0;
        bus.abort = 1'b0;
        #1;
        cyc(0, 0, 0, 32'd0, 0, 0, "rst0");
        cyc(0, 1, 0, 32'd0, 0, 0, "rst1");
        sclr = 1'b0;

        // up sweep, dwell 0
        wr_all(32'd100, 32'd130, 32'd10, 32'd0, 32'd0);
        cyc(1, 1, 0, 32'd100, 1, 0, "up_load");
        cyc(1, 0, 0, 32'd110, 1, 0, "up_110");
        cyc(1, 0, 0, 32'd120, 1, 0, "up_120");
        cyc(1, 0, 0, 32'd130, 1, 1, "up_done");
        cyc(1, 0, 0, 32'd130, 0, 0, "up_idle");
        cyc(1, 1, 0, 32'd100, 1, 0, "up_again");
        cyc(1, 1, 0, 32'd110, 1, 0, "go_in_run");
        cyc(1, 0, 1, 32'd110, 0, 0, "abort_clean");

        // down sweep with clamp and dwell 1, CE every other cycle
        wr_all(32'd1000, 32'd975, 32'd10, 32'd1, 32'd110);
        cyc(0, 1, 0, 32'd1000, 1, 0, "dn_load");
        for (int i = 1; i <= 12; i++) begin
            if (i < 3)       ef = 32'd1000;
            else if (i < 7)  ef = 32'd990;
            else if (i < 11) ef = 32'd980;
            else             ef = 32'd975;
            cyc(i[0], 0, 0, ef, (i <= 11), (i == 11), $sformatf("dn_c%0d", i));
        end

        // no wrap, upward and downward
        wr_all(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd0, 32'd975);
        cyc(1, 1, 0, 32'hFFFF_FFF0, 1, 0, "wrap_up_load");
        cyc(1, 0, 0, 32'hFFFF_FFFF, 1, 1, "wrap_up_done");
        cyc(1, 0, 0, 32'hFFFF_FFFF, 0, 0, "wrap_up_idle");
        wr_all(32'h10, 32'h0, 32'h20, 32'd0, 32'hFFFF_FFFF);
        cyc(1, 1, 0, 32'h10, 1, 0, "wrap_dn_load");
        cyc(1, 0, 0, 32'h0, 1, 1, "wrap_dn_done");
        cyc(1, 0, 0, 32'h0, 0, 0, "wrap_dn_idle");

        // abort mid-sweep, then abort+go in idle
        wr_all(32'd100, 32'd130, 32'd10, 32'd0, 32'd0);
        cyc(1, 1, 0, 32'd100, 1, 0, "ab_load");
        cyc(1, 0, 0, 32'd110, 1, 0, "ab_110");
        cyc(1, 0, 1, 32'd110, 0, 0, "ab_abort");
        cyc(1, 0, 0, 32'd110, 0, 0, "ab_hold");
        cyc(1, 1, 1, 32'd110, 0, 0, "ab_go_abort");
        cyc(1, 0, 0, 32'd110, 0, 0, "ab_still_idle");

        // repeat mode, shadow write mid-sweep, CE freeze
        bus.mode = 1'b1;
        cyc(1, 1, 0, 32'd100, 1, 0, "rp_load");
        set_wr(2'd0, 32'd50);
        cyc(1, 0, 0, 32'd110, 1, 0, "rp_110_wr");
        cyc(1, 0, 0, 32'd120, 1, 0, "rp_120");
        cyc(1, 0, 0, 32'd130, 1, 1, "rp_done1");
        cyc(1, 0, 0, 32'd50,  1, 0, "rp_reload");
        cyc(1, 0, 0, 32'd60,  1, 0, "rp_60");
        cyc(1, 0, 0, 32'd70,  1, 0, "rp_70");
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 32'd70, 1, 0, $sformatf("rp_freeze%0d", i));
        end
        for (int k = 8; k <= 13; k++) begin
            cyc(1, 0, 0, k * 10, 1, (k == 13), $sformatf("rp_%0d", k * 10));
        end
        cyc(1, 0, 1, 32'd130, 0, 0, "rp_abort_end");
        bus.mode = 1'b0;

        // synchronous reset mid-sweep clears shadows too
        wr_all(32'd100, 32'd130, 32'd10, 32'd0, 32'd130);
        cyc(1, 1, 0, 32'd100, 1, 0, "sr_load");
        cyc(1, 0, 0, 32'd110, 1, 0, "sr_110");
        sclr = 1'b1;
        cyc(1, 0, 0, 32'd0, 0, 0, "sr_reset");
        sclr = 1'b0;
        cyc(0, 1, 0, 32'd0, 1, 1, "sr_go_equal");
        cyc(0, 0, 0, 32'd0, 0, 0, "sr_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
